// File: rtl/spi_card_mux_pkg.sv
// Shared constants and the slot-to-selection encoding for the SPI card multiplexer.
package spi_card_mux_pkg;

  localparam int SEL_PHYS        = 0;
  localparam int DEF_ACT_TIMEOUT = 1000000;
  localparam int DEF_RST_PULSE   = 10000000;

  // Virtual slot i is addressed as selection i+1; 0 is reserved for the physical card.
  function automatic int slot_to_sel(input int slot);
    return slot + 1;
  endfunction

endpackage

// File: rtl/spi_card_mux_act_timer.sv
// Saturating activity counter: cleared by line activity, act_o high until it reaches the timeout.
module act_timer #(
  parameter int ACT_TIMEOUT = spi_card_mux_pkg::DEF_ACT_TIMEOUT
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr_i,
  output logic act_o
);

  localparam int CW = $clog2(ACT_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(ACT_TIMEOUT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= CW'(ACT_TIMEOUT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign act_o = (cnt_q < CW'(ACT_TIMEOUT));

endmodule

// File: rtl/spi_card_mux.sv
// Routes the core SPI master to the physical SD card or one of the virtual image slots,
// tracks per-channel activity and requests a core reset whenever an image changes.
module spi_card_mux #(
  parameter int  NUM_VSD     = 2,
  parameter int  ACT_TIMEOUT = spi_card_mux_pkg::DEF_ACT_TIMEOUT,
  parameter int  RST_PULSE   = spi_card_mux_pkg::DEF_RST_PULSE,
  localparam int SW          = $clog2(NUM_VSD + 1)
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NUM_VSD-1:0] img_mounted,
  input  logic [NUM_VSD-1:0] img_nz,
  input  logic               spi_cs_n,
  input  logic               spi_sck,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic [NUM_VSD-1:0] vsd_ss_n,
  input  logic [NUM_VSD-1:0] vsd_miso,
  output logic               sd_cs_n,
  output logic               sd_sck,
  output logic               sd_mosi,
  input  logic               sd_miso,
  output logic [SW-1:0]      active_sel,
  output logic [NUM_VSD:0]   act,
  output logic               img_reset
);
  import spi_card_mux_pkg::*;

  localparam int RW = $clog2(RST_PULSE + 1);

  logic [NUM_VSD-1:0] mnt_q, mnt_d;
  logic [SW-1:0]      target_q, target_d;
  logic [SW-1:0]      active_sel_q, active_sel_d;
  logic               mosi_prev_q, miso_prev_q;
  logic               img_reset_q;
  logic [RW-1:0]      rst_cnt_q;
  logic               miso_sel;
  logic               drop;
  logic               chg;

  // Non-zero mounts win over zero-size ones; loops run high-to-low so the lowest index sticks.
  always_comb begin
    mnt_d    = mnt_q;
    target_d = target_q;
    drop     = 1'b0;
    for (int i = 0; i < NUM_VSD; i++) begin
      if (img_mounted[i]) mnt_d[i] = img_nz[i];
      if (img_mounted[i] && !img_nz[i] && target_q == SW'(slot_to_sel(i))) drop = 1'b1;
    end
    if (|(img_mounted & img_nz)) begin
      for (int i = NUM_VSD - 1; i >= 0; i--) begin
        if (img_mounted[i] && img_nz[i]) target_d = SW'(slot_to_sel(i));
      end
    end else if (drop) begin
      target_d = SW'(SEL_PHYS);
      for (int i = NUM_VSD - 1; i >= 0; i--) begin
        if (mnt_d[i]) target_d = SW'(slot_to_sel(i));
      end
    end
    active_sel_d = spi_cs_n ? target_d : active_sel_q;
  end

  always_comb begin
    miso_sel = 1'b1;
    if (active_sel_q == SW'(SEL_PHYS)) miso_sel = sd_miso;
    for (int i = 0; i < NUM_VSD; i++) begin
      if (active_sel_q == SW'(slot_to_sel(i))) miso_sel = vsd_miso[i];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mnt_q        <= '0;
      target_q     <= '0;
      active_sel_q <= '0;
      mosi_prev_q  <= 1'b0;
      miso_prev_q  <= 1'b0;
      img_reset_q  <= 1'b0;
      rst_cnt_q    <= '0;
    end else begin
      mnt_q        <= mnt_d;
      target_q     <= target_d;
      active_sel_q <= active_sel_d;
      mosi_prev_q  <= spi_mosi;
      miso_prev_q  <= miso_sel;
      if (|img_mounted) begin
        img_reset_q <= 1'b1;
        rst_cnt_q   <= RW'(RST_PULSE - 1);
      end else if (img_reset_q) begin
        if (rst_cnt_q == '0) img_reset_q <= 1'b0;
        else                 rst_cnt_q   <= rst_cnt_q - RW'(1);
      end
    end
  end

  assign chg = (spi_mosi != mosi_prev_q) | (miso_sel != miso_prev_q);

  for (genvar k = 0; k <= NUM_VSD; k++) begin : g_act
    act_timer #(.ACT_TIMEOUT(ACT_TIMEOUT)) u_act_timer (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .clr_i   (chg && (active_sel_q == SW'(k))),
      .act_o   (act[k])
    );
  end

  for (genvar i = 0; i < NUM_VSD; i++) begin : g_ss
    assign vsd_ss_n[i] = spi_cs_n | (active_sel_q != SW'(slot_to_sel(i)));
  end

  assign sd_cs_n    = spi_cs_n | (active_sel_q != SW'(SEL_PHYS));
  assign sd_sck     = spi_sck & ~sd_cs_n;
  assign sd_mosi    = spi_mosi & ~sd_cs_n;
  assign spi_miso   = miso_sel;
  assign active_sel = active_sel_q;
  assign img_reset  = img_reset_q;

endmodule

// File: tb/tb_spi_card_mux.sv
// Directed bench for spi_card_mux with NUM_VSD=2, ACT_TIMEOUT=16, RST_PULSE=100.
module tb_spi_card_mux;

  localparam int NV = 2;
  localparam int SWB = 2;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [NV-1:0] img_mounted, img_nz, vsd_miso, vsd_ss_n;
  logic          spi_cs_n, spi_sck, spi_mosi, spi_miso;
  logic          sd_cs_n, sd_sck, sd_mosi, sd_miso;
  logic [SWB-1:0] active_sel;
  logic [NV:0]   act;
  logic          img_reset;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  spi_card_mux #(.NUM_VSD(NV), .ACT_TIMEOUT(16), .RST_PULSE(100)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .img_mounted(img_mounted), .img_nz(img_nz),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .vsd_ss_n(vsd_ss_n), .vsd_miso(vsd_miso),
    .sd_cs_n(sd_cs_n), .sd_sck(sd_sck), .sd_mosi(sd_mosi), .sd_miso(sd_miso),
    .active_sel(active_sel), .act(act), .img_reset(img_reset)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic mount(input logic [NV-1:0] m, input logic [NV-1:0] nz);
    img_mounted = m;
    img_nz      = nz;
    tick();
    img_mounted = '0;
    img_nz      = '0;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    img_mounted = '0;
    img_nz      = '0;
    vsd_miso    = '0;
    spi_cs_n    = 1'b1;
    spi_sck     = 1'b0;
    spi_mosi    = 1'b0;
    sd_miso     = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // reset state
    reset_n = 1'b0;
    img_mounted = '0; img_nz = '0; vsd_miso = '0;
    spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; sd_miso = 1'b0;
    tick();
    chk("rst_sel", active_sel, 0);
    chk("rst_act", act, 0);
    chk("rst_imgrst", img_reset, 0);
    chk("rst_ss", vsd_ss_n, 2'b11);
    chk("rst_sdcs", sd_cs_n, 1);
    reset_n = 1'b1;
    tick();
    chk("idle_act", act, 0);

    // one mosi toggle on the physical channel: act[0] high for exactly 16 cycles
    spi_mosi = 1'b1;
    tick();
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("act_hold%0d", c), act, 3'b001);
      tick();
    end
    chk("act_expired", act, 0);

    // mount slot 1 with cs_n high: selected next cycle
    do_reset();
    mount(2'b10, 2'b10);
    chk("m1_sel", active_sel, 2);
    chk("m1_imgrst", img_reset, 1);
    chk("m1_ss_idle", vsd_ss_n, 2'b11);
    chk("m1_sdcs_idle", sd_cs_n, 1);
    spi_cs_n = 1'b0; spi_sck = 1'b1; spi_mosi = 1'b1; vsd_miso = 2'b10;
    #1;
    chk("m1_ss_act", vsd_ss_n, 2'b01);
    chk("m1_sdcs_act", sd_cs_n, 1);
    chk("m1_sdsck", sd_sck, 0);
    chk("m1_sdmosi", sd_mosi, 0);
    chk("m1_miso", spi_miso, 1);
    tick();
    chk("m1_act_slot1_only", act, 3'b100);
    spi_cs_n = 1'b1; spi_sck = 1'b0;

    // mount slot 0 during a long transaction: switch deferred until cs_n rises
    do_reset();
    spi_cs_n = 1'b0;
    mount(2'b01, 2'b01);
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("hold_sel%0d", c), active_sel, 0);
      tick();
    end
    spi_sck = 1'b1; sd_miso = 1'b1;
    #1;
    chk("hold_sdsck", sd_sck, 1);
    chk("hold_sdcs", sd_cs_n, 0);
    chk("hold_miso", spi_miso, 1);
    spi_sck = 1'b0; sd_miso = 1'b0;
    spi_cs_n = 1'b1;
    #1;
    chk("hold_pre_switch", active_sel, 0);
    tick();
    chk("hold_switched", active_sel, 1);

    // zero-size unmount fallback: 2 -> 1 -> 0
    mount(2'b10, 2'b10);
    chk("fb_sel2", active_sel, 2);
    mount(2'b10, 2'b00);
    chk("fb_sel1", active_sel, 1);
    mount(2'b01, 2'b00);
    chk("fb_sel0", active_sel, 0);

    // simultaneous mounts pick lowest slot, then reset mid-pulse clears everything
    do_reset();
    mount(2'b11, 2'b11);
    chk("sim_sel", active_sel, 1);
    repeat (5) tick();
    chk("sim_imgrst", img_reset, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_sel", active_sel, 0);
    chk("arst_imgrst", img_reset, 0);
    chk("arst_act", act, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_imgrst", img_reset, 0);
    chk("post_rst_sel", active_sel, 0);

    // retriggered image-change pulse: high from t=1 to t=160
    do_reset();
    mount(2'b01, 2'b01);
    for (int t = 1; t <= 161; t++) begin
      chk($sformatf("pulse_t%0d", t), img_reset, (t <= 160) ? 1 : 0);
      if (t == 60) mount(2'b01, 2'b01);
      else         tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_card_mux.md
SPI_CARD_MUX -- requirements
Module: spi_card_mux

Interface
REQ-001 SHALL have parameter NUM_VSD, default 2, number of virtual SD slots (1..4).
REQ-002 SHALL have parameter ACT_TIMEOUT, default 1000000, activity hold time in clk_sys cycles.
REQ-003 SHALL have parameter RST_PULSE, default 10000000, image-change reset length in cycles.
REQ-004 SHALL have localparam SW = clog2(NUM_VSD+1), the selection width.
REQ-005 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 img_mounted  in  NUM_VSD  one-cycle mount pulse per slot.
REQ-008 img_nz  in  NUM_VSD  image size non-zero, valid with img_mounted.
REQ-009 spi_cs_n, spi_sck, spi_mosi  in  1 each  core SPI master.
REQ-010 spi_miso  out  1  muxed MISO to core.
REQ-011 vsd_ss_n  out  NUM_VSD  per-slot select to virtual card models.
REQ-012 vsd_miso  in  NUM_VSD  per-slot MISO from virtual card models.
REQ-013 sd_cs_n, sd_sck, sd_mosi  out  1 each  physical card pins.
REQ-014 sd_miso  in  1  physical card MISO.
REQ-015 active_sel  out  SW  0 = physical, i+1 = virtual slot i.
REQ-016 act  out  NUM_VSD+1  activity flags; bit 0 physical, bit i+1 slot i.
REQ-017 img_reset  out  1  core cold-reset request.

Function
REQ-018 mnt[i] SHALL set on img_mounted[i]&img_nz[i] and clear on img_mounted[i]&~img_nz[i].
REQ-019 target SHALL become i+1 on non-zero mount of slot i; simultaneous mounts pick lowest index.
REQ-020 Zero-size mount of the targeted slot SHALL move target to the lowest remaining mounted slot, else 0.
REQ-021 active_sel SHALL load target only on a cycle where spi_cs_n is 1; held while spi_cs_n is 0 (no switch mid-transaction).
REQ-022 Latency mount pulse -> active_sel SHALL be 1 cycle when spi_cs_n is 1.
REQ-023 vsd_ss_n[i] SHALL be spi_cs_n | (active_sel != i+1), combinational.
REQ-024 sd_cs_n SHALL be spi_cs_n | (active_sel != 0); sd_sck = spi_sck & ~sd_cs_n; sd_mosi = spi_mosi & ~sd_cs_n.
REQ-025 spi_miso SHALL be sd_miso when active_sel = 0, else vsd_miso[active_sel-1]; out-of-range selection yields 1.
REQ-026 Each channel SHALL own a saturating counter; a change of spi_mosi or selected MISO vs. previous cycle, while that channel is active_sel, clears it.
REQ-027 act[k] SHALL be 1 while counter k < ACT_TIMEOUT; counter stops at ACT_TIMEOUT.
REQ-028 Non-selected channels SHALL keep counting to saturation regardless of line toggles.
REQ-029 Any img_mounted bit SHALL assert img_reset and load a down-counter with RST_PULSE-1; img_reset drops when it reaches 0.
REQ-030 A mount during an active pulse SHALL reload the counter (retrigger), no glitch low.

Reset
REQ-031 On reset_n=0: mnt=0, target=0, active_sel=0, img_reset=0, act=0, all activity counters = ACT_TIMEOUT, edge history = 0.
REQ-032 Reset mid-pulse or mid-transaction SHALL abort immediately with no residual state.

Structure
REQ-033 A shared package SHALL hold SEL_PHYS = 0 constant, the slot-to-selection encoding function and the default timing constants.
REQ-034 One sub-module act_timer (single saturating activity counter, parameter ACT_TIMEOUT) SHALL be instantiated NUM_VSD+1 times.

Verification
REQ-035 Mount slot 1 nz with spi_cs_n=1 -> active_sel=2 next cycle, vsd_ss_n[1] follows spi_cs_n, sd_cs_n=1.
REQ-036 Mount slot 0 nz while spi_cs_n=0 for 50 cycles -> active_sel stays 0 until first cycle with spi_cs_n=1, then 1.
REQ-037 Slots 0,1 mounted, target=2; zero-size mount slot 1 -> target=1; zero-size mount slot 0 -> target=0.
REQ-038 ACT_TIMEOUT=16: toggle spi_mosi once on physical -> act[0]=1 for exactly 16 cycles then 0; act[1..] stay 0.
REQ-039 RST_PULSE=100: mount at t=0 and t=60 -> img_reset high continuously from t=1 to t=160.
REQ-040 Simultaneous nz mounts on slots 0 and 1 -> target=1; reset_n pulse mid-img_reset -> all outputs at REQ-031 values.
